// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around the port arbiter.
`default_nettype none

// ============================================================================
//  Module   : mem_port_if
//  Purpose  : CPU requester ports plus the shared memory port, as one bundle
//  Revision : 1.0  initial release
// ============================================================================
interface mem_port_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_err;

  logic        ls_req;
  logic        ls_we;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_done;
  logic        ls_err;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  // Arbiter side: consumes requests and memory responses, drives the rest.
  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_done, if_err,
    input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    output ls_rdata, ls_done, ls_err,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  // Environment side: the core requesters and the memory model.
  modport master (
    output if_req, if_addr,
    input  if_rdata, if_done, if_err,
    output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    input  ls_rdata, ls_done, ls_err,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch vs load/store) for a single 32-bit memory port,
// one outstanding transaction, LS priority with a burst limit, and ack timeout.
`default_nettype none

// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : IF/LS arbitration onto one memory port with starvation guard
//             and no-ack timeout error reporting
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int LS_BURST_MAX = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic       clk,
  input  logic       reset,
  mem_port_if.slave  bus
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int SW = (LS_BURST_MAX < 1) ? 1 : $clog2(LS_BURST_MAX + 1);

  localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(LS_BURST_MAX);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic          owner_ls;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] streak;

  logic grant_ls;
  logic grant_if;

  // LS wins ties until it has taken LS_BURST_MAX grants in a row over a waiting fetch.
  always_comb begin
    grant_ls = 1'b0;
    grant_if = 1'b0;
    if (bus.ls_req && (!bus.if_req || (streak != STREAK_MAX))) begin
      grant_ls = 1'b1;
    end else if (bus.if_req) begin
      grant_if = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      owner_ls      <= 1'b0;
      tcnt          <= '0;
      streak        <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= 4'h0;
      bus.mem_addr  <= 32'h0;
      bus.mem_wdata <= 32'h0;
      bus.if_done   <= 1'b0;
      bus.if_err    <= 1'b0;
      bus.if_rdata  <= 32'h0;
      bus.ls_done   <= 1'b0;
      bus.ls_err    <= 1'b0;
      bus.ls_rdata  <= 32'h0;
    end else begin
      // Completion outputs are single-cycle; they fall back to zero unless set below.
      bus.if_done  <= 1'b0;
      bus.if_err   <= 1'b0;
      bus.if_rdata <= 32'h0;
      bus.ls_done  <= 1'b0;
      bus.ls_err   <= 1'b0;
      bus.ls_rdata <= 32'h0;

      case (state)
        IDLE: begin
          if (grant_ls) begin
            owner_ls      <= 1'b1;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.ls_we;
            bus.mem_be    <= bus.ls_be;
            bus.mem_addr  <= bus.ls_addr;
            bus.mem_wdata <= bus.ls_wdata;
            tcnt          <= '0;
            state         <= BUSY;
            if (!bus.if_req) begin
              streak <= '0;
            end else if (streak != STREAK_MAX) begin
              streak <= streak + 1'b1;
            end
          end else if (grant_if) begin
            owner_ls      <= 1'b0;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= 4'hF;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_wdata <= 32'h0;
            tcnt          <= '0;
            streak        <= '0;
            state         <= BUSY;
          end
        end

        BUSY: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            state       <= RESP;
            if (owner_ls) begin
              bus.ls_done  <= 1'b1;
              bus.ls_rdata <= bus.mem_we ? 32'h0 : bus.mem_rdata;
            end else begin
              bus.if_done  <= 1'b1;
              bus.if_rdata <= bus.mem_rdata;
            end
          end else if (tcnt == TCNT_LAST) begin
            // This was the TIMEOUT-th cycle with mem_req high and still no ack.
            bus.mem_req <= 1'b0;
            state       <= RESP;
            if (owner_ls) begin
              bus.ls_done <= 1'b1;
              bus.ls_err  <= 1'b1;
            end else begin
              bus.if_done <= 1'b1;
              bus.if_err  <= 1'b1;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state       <= IDLE;
          bus.mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (LS_BURST_MAX=4, TIMEOUT=8).
`default_nettype none

// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : directed stimulus with hand-computed expectations
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam logic [31:0] IF_A = 32'h0000_0100;
  localparam logic [31:0] LS_A = 32'h2000_0004;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  mem_port_if bus ();

  mem_port_arbiter #(
    .LS_BURST_MAX (4),
    .TIMEOUT      (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int          cnt;
    int          w;
    logic [9:0]  exp_ord;

    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'h0;
    bus.ls_req    = 1'b0;
    bus.ls_we     = 1'b0;
    bus.ls_be     = 4'hF;
    bus.ls_addr   = 32'h0;
    bus.ls_wdata  = 32'h0;
    bus.mem_rdata = 32'h0;
    bus.mem_ack   = 1'b0;
    tick();
    tick();
    chk("rst_mem_req",  bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_be",   bus.mem_be, 0);
    chk("rst_if_done",  bus.if_done, 0);
    chk("rst_ls_done",  bus.ls_done, 0);
    reset = 1'b0;
    tick();

    // 1: fetch alone, ack in second memory cycle
    bus.if_req  = 1'b1;
    bus.if_addr = IF_A;
    tick();
    chk("t1_req_c1", bus.mem_req, 1);
    chk("t1_addr",   bus.mem_addr, IF_A);
    chk("t1_be",     bus.mem_be, 32'hF);
    chk("t1_we",     bus.mem_we, 0);
    tick();
    chk("t1_req_c2", bus.mem_req, 1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hE3A0_0001;
    tick();
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    chk("t1_done",  bus.if_done, 1);
    chk("t1_rdata", bus.if_rdata, 32'hE3A0_0001);
    chk("t1_err",   bus.if_err, 0);
    chk("t1_ls_done", bus.ls_done, 0);
    chk("t1_req_off", bus.mem_req, 0);
    tick();
    chk("t1_done_pulse", bus.if_done, 0);
    chk("t1_rdata_clr",  bus.if_rdata, 0);

    // 2: tie, LS first then IF
    bus.if_req  = 1'b1;
    bus.ls_req  = 1'b1;
    bus.ls_addr = LS_A;
    tick();
    chk("t2_ls_first", bus.mem_addr, LS_A);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1111_2222;
    tick();
    bus.mem_ack = 1'b0;
    bus.ls_req  = 1'b0;
    chk("t2_ls_done",  bus.ls_done, 1);
    chk("t2_ls_rdata", bus.ls_rdata, 32'h1111_2222);
    chk("t2_if_quiet", bus.if_done, 0);
    tick();
    chk("t2_idle_req", bus.mem_req, 0);
    tick();
    chk("t2_if_req",  bus.mem_req, 1);
    chk("t2_if_addr", bus.mem_addr, IF_A);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h3333_4444;
    tick();
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    chk("t2_if_done",  bus.if_done, 1);
    chk("t2_ls_quiet", bus.ls_done, 0);
    tick();

    // 3: starvation guard, both held, 1-cycle ack
    exp_ord = 10'b0111101111;
    bus.if_req = 1'b1;
    bus.ls_req = 1'b1;
    for (int n = 0; n < 10; n++) begin
      w = 0;
      while (bus.mem_req !== 1'b1 && w < 10) begin
        tick();
        w++;
      end
      chk($sformatf("t3_req_%0d", n), bus.mem_req, 1);
      chk($sformatf("t3_owner_ls_%0d", n), {31'h0, bus.mem_addr == LS_A}, {31'h0, exp_ord[n]});
      if (!exp_ord[n]) chk($sformatf("t3_if_we_%0d", n), bus.mem_we, 0);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h5000_0000 + n;
      tick();
      bus.mem_ack = 1'b0;
      chk($sformatf("t3_done_%0d", n),
          exp_ord[n] ? bus.ls_done : bus.if_done, 1);
    end
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    tick();

    // 4a: timeout on a read
    bus.ls_addr   = 32'h0000_3000;
    bus.ls_we     = 1'b0;
    bus.mem_rdata = 32'hDEAD_BEEF;
    bus.ls_req    = 1'b1;
    tick();
    cnt = 0;
    while (bus.mem_req === 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
    bus.ls_req = 1'b0;
    chk("t4_req_cycles", cnt, 8);
    chk("t4_done",  bus.ls_done, 1);
    chk("t4_err",   bus.ls_err, 1);
    chk("t4_rdata", bus.ls_rdata, 0);
    tick();
    chk("t4_err_pulse", bus.ls_err, 0);
    tick();

    // 4b: ack on the 8th (last) cycle succeeds
    bus.ls_req = 1'b1;
    tick();
    for (int k = 1; k < 8; k++) tick();
    chk("t4b_req_c8", bus.mem_req, 1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    tick();
    bus.mem_ack = 1'b0;
    bus.ls_req  = 1'b0;
    chk("t4b_done",  bus.ls_done, 1);
    chk("t4b_err",   bus.ls_err, 0);
    chk("t4b_rdata", bus.ls_rdata, 32'h1234_5678);
    tick();

    // 5: write, payload changes while granted are ignored
    bus.ls_we     = 1'b1;
    bus.ls_be     = 4'b0011;
    bus.ls_addr   = 32'h0000_2000;
    bus.ls_wdata  = 32'hCAFE_BABE;
    bus.mem_rdata = 32'h55AA_55AA;
    bus.ls_req    = 1'b1;
    tick();
    bus.ls_addr  = 32'h0000_9999;
    bus.ls_wdata = 32'h0;
    chk("t5_we",    bus.mem_we, 1);
    chk("t5_be",    bus.mem_be, 32'h3);
    chk("t5_wdata", bus.mem_wdata, 32'hCAFE_BABE);
    tick();
    chk("t5_addr_hold", bus.mem_addr, 32'h0000_2000);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    bus.ls_req  = 1'b0;
    bus.ls_we   = 1'b0;
    bus.ls_be   = 4'hF;
    chk("t5_done",  bus.ls_done, 1);
    chk("t5_rdata", bus.ls_rdata, 0);
    tick();

    // 6: reset mid-wait, late ack ignored
    bus.ls_addr = 32'h0000_4000;
    bus.ls_req  = 1'b1;
    tick();
    tick();
    chk("t6_busy", bus.mem_req, 1);
    reset      = 1'b1;
    bus.ls_req = 1'b0;
    tick();
    reset = 1'b0;
    chk("t6_req_off", bus.mem_req, 0);
    chk("t6_addr",    bus.mem_addr, 0);
    chk("t6_we",      bus.mem_we, 0);
    chk("t6_done",    bus.ls_done, 0);
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h7777_7777;
    tick();
    bus.mem_ack = 1'b0;
    chk("t6_late_req",  bus.mem_req, 0);
    chk("t6_late_done", bus.ls_done, 0);
    tick();
    chk("t6_late_done2", bus.ls_done, 0);
    chk("t6_late_err",   bus.ls_err, 0);
    chk("t6_late_ifd",   bus.if_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
